dfm_measure: RTL and testbench
==============================

# dfm_measure

Equal-precision frequency/period measurement engine for the digital frequency meter. It consumes the 32-bit gate time from the register file and synchronises the gate to edges of the measured signal. Over an integer number of signal periods it counts both reference clock cycles and signal rising edges. Each result is written back into the register file's result words (byte registers 8..15) as one 64-bit write.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 32'd50_000_000: maximum number of cycles to wait for a signal edge in ARM or CLOSE.

Ports:
- clk_i  in  1  reference clock; all counts are in clk_i cycles
- rst_n_i  in  1  reset; asynchronous assert, active-low
- en_i  in  1  run enable; level-sensitive
- sig_i  in  1  measured signal; asynchronous to clk_i
- gate_time_i  in  32  gate length in clk_i cycles (register file gate-time output)
- res_wr_en_o  out  1  one-cycle result write strobe (to register file write enable)
- res_wr_addr_o  out  3  constant 3'b100; selects the 64-bit result write
- res_wr_data_o  out  64  {sig_cnt[31:0], ref_cnt[31:0]}
- busy_o  out  1  high in any state other than IDLE

## Operation
- Input conditioning:
  - sig_i passes through a 2-flop synchroniser, then an edge detector.
  - sig_rise = s_sync & ~s_prev.
  - No other logic samples sig_i.
- States: IDLE, ARM, GATE, CLOSE, DONE.
- IDLE:
  - Counters are held.
  - Goes to ARM when en_i=1.
- ARM:
  - Waits for sig_rise, which is the opening edge.
  - On the opening edge: clear ref_cnt and sig_cnt, load gate_cnt with max(gate_time_i,1), then go to GATE.
  - gate_time_i is sampled only at this point. Later changes affect only the next measurement.
- GATE:
  - Every cycle: ref_cnt += 1 and gate_cnt -= 1.
  - On sig_rise: sig_cnt += 1.
  - When gate_cnt==1 (the last gate cycle), go to CLOSE.
  - A sig_rise in the last gate cycle is counted but does not close the gate.
- CLOSE:
  - Every cycle: ref_cnt += 1.
  - The first sig_rise is the closing edge: sig_cnt += 1, then go to DONE.
- DONE:
  - Lasts one cycle.
  - res_wr_en_o=1; res_wr_data_o holds the final counts.
  - Next state is ARM if en_i=1, otherwise IDLE.
  - The closing edge is not reused as the next opening edge.
- Result meaning: sig_cnt = number of whole signal periods; ref_cnt = cycles between the opening and closing edges. Software computes f_sig = f_clk·sig_cnt/ref_cnt.
- Arithmetic: ref_cnt and sig_cnt are 32-bit and saturate at 32'hFFFF_FFFF (no wrap).
- Timeout:
  - to_cnt clears on entry to ARM and to CLOSE, and increments each cycle spent in either state.
  - Reaching TIMEOUT_CYCLES before an edge goes to DONE with data {32'h0, 32'hFFFF_FFFF}.
  - sig_cnt=0 marks the result invalid.
- Abort: en_i=0 in ARM, GATE or CLOSE returns to IDLE next cycle. Nothing is written and outputs are unchanged.

## Timing
- Reset values: state=IDLE; res_wr_en_o=0, res_wr_addr_o=3'b100, res_wr_data_o=64'h0, busy_o=0; all internal counters 0; synchroniser flops 0.
- Edge latency: sig_i first sampled high at clock edge k → sig_rise is high in the cycle after edge k+2.
- Measurement window: with the opening sig_rise in cycle t0 and the closing sig_rise in cycle t1, ref_cnt = t1 − t0 exactly.
- GATE covers cycles t0+1 .. t0+G, where G = max(gate_time_i,1). CLOSE starts at t0+G+1.
- Result output: res_wr_en_o is high for exactly cycle t1+1. res_wr_data_o is registered, stable in that cycle, and held afterwards until the next write.
- Throughput: the next ARM starts at t1+2. The minimum spacing between writes is G + 1 signal period + 2 cycles.
- Reset asserted mid-measurement: immediate return to reset values; no partial write.
- en_i is sampled synchronously every cycle. A rising en_i in IDLE reaches ARM on the next cycle.

## Test plan
- Signal period 10 cycles, gate_time=95 → sig_cnt=10, ref_cnt=100. res_wr_en_o is one cycle wide, with res_wr_data_o=64'h0000000A_00000064 and addr=3'b100.
- Same signal, gate_time=100 → the edge on the last gate cycle is counted without closing; result sig_cnt=11, ref_cnt=110.
- gate_time=0, period 7 → treated as G=1; result sig_cnt=1, ref_cnt=7. Back-to-back measurements with en_i held high give identical results, spaced ≥ 9 cycles apart.
- sig_i held low, TIMEOUT_CYCLES=1000 → a write with {32'h0, 32'hFFFF_FFFF} exactly 1000 cycles after entering ARM. Repeat with the signal stopping during CLOSE.
- en_i dropped during GATE, and separately rst_n_i pulsed mid-CLOSE → no res_wr_en_o pulse, busy_o=0 the next cycle, and all outputs back at reset values after the reset.
- Change gate_time_i during GATE → the current result still uses the old G; the next measurement uses the new G.

Source files
------------

// File: rtl/dfm_measure.sv
// Equal-precision frequency/period measurement engine: counts reference cycles
// and signal edges over an integer number of signal periods.
module dfm_measure #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        sig_i,
    input  logic [31:0] gate_time_i,
    output logic        res_wr_en_o,
    output logic [2:0]  res_wr_addr_o,
    output logic [63:0] res_wr_data_o,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | stopped, counters held
    // ARM   | waiting for the opening signal edge
    // GATE  | gate open, counting reference cycles and signal edges
    // CLOSE | gate expired, waiting for the closing signal edge
    // DONE  | one-cycle result write
    typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, DONE} state_t;

    localparam logic [63:0] TIMEOUT_WORD = {32'h0000_0000, 32'hFFFF_FFFF};

    state_t      state, state_nxt;
    logic        s_meta, s_sync, s_prev, sig_rise;
    logic [31:0] ref_cnt, sig_cnt, gate_cnt, to_cnt;
    logic [63:0] res_data;
    logic        timeout_hit;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Edge pulse is registered so it is a clean single-cycle strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_meta   <= 1'b0;
            s_sync   <= 1'b0;
            s_prev   <= 1'b0;
            sig_rise <= 1'b0;
        end else begin
            s_meta   <= sig_i;
            s_sync   <= s_meta;
            s_prev   <= s_sync;
            sig_rise <= s_sync & ~s_prev;
        end
    end

    assign timeout_hit = ({1'b0, to_cnt} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (en_i) state_nxt = ARM;
            ARM: begin
                if (!en_i)            state_nxt = IDLE;
                else if (sig_rise)    state_nxt = GATE;
                else if (timeout_hit) state_nxt = DONE;
            end
            GATE: begin
                if (!en_i)                 state_nxt = IDLE;
                else if (gate_cnt <= 32'd1) state_nxt = CLOSE;
            end
            CLOSE: begin
                if (!en_i)                         state_nxt = IDLE;
                else if (sig_rise || timeout_hit)  state_nxt = DONE;
            end
            DONE:    state_nxt = en_i ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ref_cnt  <= 32'd0;
            sig_cnt  <= 32'd0;
            gate_cnt <= 32'd0;
            res_data <= 64'd0;
        end else if (en_i) begin
            case (state)
                ARM: begin
                    if (sig_rise) begin
                        ref_cnt  <= 32'd0;
                        sig_cnt  <= 32'd0;
                        gate_cnt <= (gate_time_i == 32'd0) ? 32'd1 : gate_time_i;
                    end else if (timeout_hit) begin
                        res_data <= TIMEOUT_WORD;
                    end
                end
                GATE: begin
                    ref_cnt  <= sat_inc(ref_cnt);
                    gate_cnt <= gate_cnt - 32'd1;
                    if (sig_rise) sig_cnt <= sat_inc(sig_cnt);
                end
                CLOSE: begin
                    ref_cnt <= sat_inc(ref_cnt);
                    if (sig_rise) begin
                        sig_cnt  <= sat_inc(sig_cnt);
                        res_data <= {sat_inc(sig_cnt), sat_inc(ref_cnt)};
                    end else if (timeout_hit) begin
                        res_data <= TIMEOUT_WORD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Edge wait timer restarts whenever ARM or CLOSE is freshly entered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt <= 32'd0;
        end else if ((state_nxt != state) && (state_nxt == ARM || state_nxt == CLOSE)) begin
            to_cnt <= 32'd0;
        end else if (state == ARM || state == CLOSE) begin
            to_cnt <= sat_inc(to_cnt);
        end
    end

    assign res_wr_en_o   = (state == DONE);
    assign res_wr_addr_o = 3'b100;
    assign res_wr_data_o = res_data;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_dfm_measure.sv
// Directed self-checking bench for dfm_measure with a clock-synchronous test signal.
module tb_dfm_measure;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic        sig_i = 1'b0;
    logic [31:0] gate_time_i = 32'd0;
    logic        res_wr_en_o;
    logic [2:0]  res_wr_addr_o;
    logic [63:0] res_wr_data_o;
    logic        busy_o;

    int total = 0;
    int bad = 0;
    int sig_period = 0;
    int ph = 0;

    dfm_measure #(.TIMEOUT_CYCLES(32'd1000)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .en_i          (en_i),
        .sig_i         (sig_i),
        .gate_time_i   (gate_time_i),
        .res_wr_en_o   (res_wr_en_o),
        .res_wr_addr_o (res_wr_addr_o),
        .res_wr_data_o (res_wr_data_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Periodic test signal: high for period/2 cycles, rising every period cycles.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (sig_period == 0) begin
                sig_i = 1'b0;
                ph = 0;
            end else begin
                sig_i = (ph < sig_period / 2);
                ph = (ph + 1 >= sig_period) ? 0 : ph + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int budget, output logic [63:0] d, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        d = 64'h0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            cyc++;
            if (res_wr_en_o) begin
                ok = 1'b1;
                d = res_wr_data_o;
                break;
            end
        end
    endtask

    task automatic idle_all();
        tick();
        en_i = 1'b0;
        sig_period = 0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        total++; if (res_wr_en_o !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", res_wr_en_o); end
        total++; if (res_wr_addr_o !== 3'b100) begin bad++; $display("FAIL reset_addr got=%b exp=100", res_wr_addr_o); end
        total++; if (res_wr_data_o !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", res_wr_data_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        tick();
        rst_n_i = 1'b1;
        repeat (2) tick();
    endtask

    task automatic run_one(input string name, input logic [31:0] gate, input int period,
                           input logic [63:0] exp);
        bit ok;
        logic [63:0] d;
        int cyc;
        gate_time_i = gate;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_arm busy never rose", name); end
        sig_period = period;
        wait_wr(400, d, cyc, ok);
        total++; if (!ok || d !== exp) begin bad++; $display("FAIL %s_data got=%h exp=%h ok=%0d", name, d, exp, ok); end
        total++; if (res_wr_addr_o !== 3'b100) begin bad++; $display("FAIL %s_addr got=%b exp=100", name, res_wr_addr_o); end
        @(negedge clk_i);
        total++; if (res_wr_en_o !== 1'b0) begin bad++; $display("FAIL %s_strobe_width got=%b exp=0", name, res_wr_en_o); end
        total++; if (res_wr_data_o !== exp) begin bad++; $display("FAIL %s_hold got=%h exp=%h", name, res_wr_data_o, exp); end
        idle_all();
    endtask

    task automatic test_basic();
        run_one("basic", 32'd95, 10, 64'h0000000A_00000064);
    endtask

    task automatic test_last_edge();
        run_one("last_edge", 32'd100, 10, 64'h0000000B_0000006E);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [63:0] d1, d2;
        int cyc;
        gate_time_i = 32'd0;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_arm busy never rose"); end
        sig_period = 7;
        wait_wr(200, d1, cyc, ok);
        total++; if (!ok || d1 !== 64'h00000001_00000007) begin bad++; $display("FAIL b2b_first got=%h exp=0000000100000007", d1); end
        wait_wr(200, d2, cyc, ok);
        total++; if (!ok || d2 !== 64'h00000001_00000007) begin bad++; $display("FAIL b2b_second got=%h exp=0000000100000007", d2); end
        total++; if (cyc != 14) begin bad++; $display("FAIL b2b_spacing got=%0d exp=14", cyc); end
        idle_all();
    endtask

    task automatic test_timeout_low();
        bit ok;
        logic [63:0] d;
        int cyc;
        gate_time_i = 32'd95;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_low_arm busy never rose"); end
        wait_wr(1100, d, cyc, ok);
        total++; if (!ok || cyc != 1000) begin bad++; $display("FAIL to_low_delay got=%0d exp=1000 ok=%0d", cyc, ok); end
        total++; if (d !== 64'h00000000_FFFFFFFF) begin bad++; $display("FAIL to_low_data got=%h exp=00000000ffffffff", d); end
        idle_all();
    endtask

    task automatic test_timeout_close();
        bit ok;
        logic [63:0] d;
        int cyc;
        gate_time_i = 32'd50;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_close_arm busy never rose"); end
        sig_period = 10;
        repeat (45) tick();
        sig_period = 0;
        wait_wr(1200, d, cyc, ok);
        total++; if (!ok || d !== 64'h00000000_FFFFFFFF) begin bad++; $display("FAIL to_close_data got=%h exp=00000000ffffffff ok=%0d", d, ok); end
        idle_all();
    endtask

    task automatic test_gate_change();
        bit ok;
        logic [63:0] d;
        int cyc;
        gate_time_i = 32'd95;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL gchg_arm busy never rose"); end
        sig_period = 10;
        repeat (30) tick();
        gate_time_i = 32'd100;
        wait_wr(400, d, cyc, ok);
        total++; if (!ok || d !== 64'h0000000A_00000064) begin bad++; $display("FAIL gchg_old got=%h exp=0000000a00000064", d); end
        wait_wr(400, d, cyc, ok);
        total++; if (!ok || d !== 64'h0000000B_0000006E) begin bad++; $display("FAIL gchg_new got=%h exp=0000000b0000006e", d); end
        idle_all();
    endtask

    task automatic test_abort_gate();
        bit ok;
        bit seen;
        gate_time_i = 32'd95;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL abort_arm busy never rose"); end
        sig_period = 10;
        repeat (30) tick();
        en_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk_i);
            if (res_wr_en_o) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_nowrite got=1 exp=0"); end
        total++; if (res_wr_data_o !== 64'h0000000B_0000006E) begin bad++; $display("FAIL abort_hold got=%h exp=0000000b0000006e", res_wr_data_o); end
        idle_all();
    endtask

    task automatic test_reset_close();
        bit ok;
        bit seen;
        gate_time_i = 32'd20;
        en_i = 1'b1;
        wait_busy(ok);
        total++; if (!ok) begin bad++; $display("FAIL rstc_arm busy never rose"); end
        sig_period = 50;
        repeat (40) tick();
        rst_n_i = 1'b0;
        en_i = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstc_busy got=%b exp=0", busy_o); end
        total++; if (res_wr_en_o !== 1'b0) begin bad++; $display("FAIL rstc_wr_en got=%b exp=0", res_wr_en_o); end
        total++; if (res_wr_data_o !== 64'h0) begin bad++; $display("FAIL rstc_data got=%h exp=0", res_wr_data_o); end
        total++; if (res_wr_addr_o !== 3'b100) begin bad++; $display("FAIL rstc_addr got=%b exp=100", res_wr_addr_o); end
        tick();
        rst_n_i = 1'b1;
        seen = 1'b0;
        repeat (120) begin
            @(negedge clk_i);
            if (res_wr_en_o || busy_o) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL rstc_quiet got=1 exp=0"); end
        sig_period = 0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_last_edge();
        test_back_to_back();
        test_timeout_low();
        test_timeout_close();
        test_gate_change();
        test_abort_gate();
        test_reset_close();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
